mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage; consumes its pipeline registers (ALU result, store data, control bits).
- Performs loads/stores through a req/ack data-memory port with byte/half/word sizing and load extension.
- Provides MEM-stage forwarding values back to execute, and drives the MEM/WB pipeline register into writeback.
- Asserts FREEZE to stall upstream stages while a memory access is outstanding.

Parameters:
- TIMEOUT, 64, cycles to wait for dmem_ack before aborting with bus error (≥2)
- CNT_W, 7, width of the wait counter; must hold TIMEOUT

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- valid_in  in  1  execute-stage output holds a real instruction (0 = bubble)
- aluResult1_PR  in  32  ALU result / effective address
- readDataB1_PR  in  32  store data
- writeRegister1_PR  in  5  destination register
- do_writeback1_PR  in  1  instruction writes a register
- MemRead1_PR  in  1  load
- MemWrite1_PR  in  1  store
- MemtoReg1_PR  in  1  WB selects memory data
- mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_signed  in  1  sign-extend sub-word loads
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  request accepted/completed; dmem_rdata valid the same cycle
- dmem_rdata  in  32  read word
- FREEZE  out  1  stall upstream stages
- Data1_MEM  out  32  forwarding value (= aluResult1_PR)
- writeRegister1_MEM  out  5  forwarding destination
- do_writeback1_MEM  out  1  forwarding valid
- aluResult1_WB  out  32  registered ALU result
- memData1_WB  out  32  registered, extended load data
- writeRegister1_WB  out  5  registered destination
- do_writeback1_WB  out  1  registered writeback enable
- MemtoReg1_WB  out  1  registered select
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (RESET high at posedge): all *_WB outputs, bus_err, and the counter → 0; state → IDLE. Combinational outputs follow from state IDLE. Any in-flight access is abandoned; dmem_req is low from the next cycle.
- States:
  - IDLE: if valid_in & (MemRead1_PR|MemWrite1_PR), dmem_req=1 combinationally.
    - Ack same cycle → access completes; stay IDLE; FREEZE=0.
    - No ack → go to WAIT; FREEZE=1.
  - WAIT: dmem_req=1; address, data, be, and we held stable (upstream is frozen); FREEZE=1 until the completing cycle.
    - dmem_ack → IDLE; FREEZE=0 that cycle.
    - Counter reaches TIMEOUT-1 without ack → IDLE, bus_err←1, load writeback suppressed.
- Non-memory valid instruction: no request; registered into WB next cycle (latency 1).
- Memory access latency: 1 cycle after ack.
- While FREEZE=1, the WB register loads a bubble (do_writeback1_WB=0).
- Bubble input (valid_in=0): do_writeback1_WB←0.
- Byte enables (little-endian, a=addr[1:0]):
  - byte: be=1<<a
  - half: be=a[1]?1100:0011
  - word: be=1111
- Store data replication:
  - byte: {4{d[7:0]}}
  - half: {2{d[15:0]}}
  - word: d
- Loads: select byte/half lane by a, then zero- or sign-extend per mem_signed. Misaligned addresses are ignored in the base build: a[0] is dropped for half, a[1:0] for word.
- dmem_we = MemWrite1_PR. MemRead & MemWrite both set: treated as store.
- Forwarding: do_writeback1_MEM = valid_in & do_writeback1_PR & ~MemRead1_PR. Loads are not forwardable from MEM; ID hazard logic inserts the bubble.
- Counter: cleared in IDLE, increments in WAIT.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - Half access with a[0]=1, or word access with a≠00, issues no request and raises misalign_err (extra 1-bit output, registered, sticky until RESET).
  - Instruction completes in 1 cycle with do_writeback1_WB=0.
- Undefined: no port; addresses are silently aligned as above.

Test Plan:
- ALU op, aluResult1_PR=0x1234, rd=5, valid → next cycle aluResult1_WB=0x1234, writeRegister1_WB=5, do_writeback1_WB=1; dmem_req never high.
- Byte store d=0x000000AB, addr=0x103, ack same cycle → dmem_be=1000, dmem_wdata=0xABABABAB, dmem_addr=0x100, FREEZE=0.
- Signed half load addr=0x202, rdata=0x8001_7FFF, ack after 3 cycles → FREEZE high exactly 3 cycles, request stable, memData1_WB=0xFFFF8001.
- Load with ack never asserted, TIMEOUT=64 → FREEZE deasserts after 64 cycles, bus_err=1, do_writeback1_WB=0.
- RESET asserted in WAIT → next cycle dmem_req=0, FREEZE=0, all WB outputs 0.
- Load to rd=7 → do_writeback1_MEM=0; ALU op to rd=7 → do_writeback1_MEM=1, Data1_MEM=aluResult1_PR.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data-memory req/ack port, sub-word load/store sizing,
// MEM forwarding and the MEM/WB register. Optional MEM_MISALIGN_TRAP_EN adds misalign_err.
module mem_stage #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        valid_in,
  input  logic [31:0] aluResult1_PR,
  input  logic [31:0] readDataB1_PR,
  input  logic [4:0]  writeRegister1_PR,
  input  logic        do_writeback1_PR,
  input  logic        MemRead1_PR,
  input  logic        MemWrite1_PR,
  input  logic        MemtoReg1_PR,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        FREEZE,
  output logic [31:0] Data1_MEM,
  output logic [4:0]  writeRegister1_MEM,
  output logic        do_writeback1_MEM,
  output logic [31:0] aluResult1_WB,
  output logic [31:0] memData1_WB,
  output logic [4:0]  writeRegister1_WB,
  output logic        do_writeback1_WB,
  output logic        MemtoReg1_WB,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalign_err,
`endif
  output logic        bus_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       lane;
  logic             mem_acc;
  logic             misalign;
  logic             req_ok;
  logic             timeout_hit;
  logic             abort;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] a,
                                              input logic sgn, input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   return sgn ? 32'(b) : {24'b0, b};
      2'b01:   return sgn ? 32'(h) : {16'b0, h};
      default: return w;
    endcase
  endfunction

  assign lane    = aluResult1_PR[1:0];
  assign mem_acc = valid_in & (MemRead1_PR | MemWrite1_PR);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = mem_acc & (((mem_size == 2'b01) & lane[0]) | (mem_size[1] & (lane != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign req_ok      = mem_acc & ~misalign;
  assign timeout_hit = (state == S_WAIT) & (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Request/stall control; upstream is frozen during WAIT so the PR inputs stay stable
  always_comb begin
    state_n  = state;
    dmem_req = 1'b0;
    FREEZE   = 1'b0;
    abort    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_ok) begin
          dmem_req = 1'b1;
          if (!dmem_ack) begin
            FREEZE  = 1'b1;
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_n = S_IDLE;
        end else if (timeout_hit) begin
          state_n = S_IDLE;
          abort   = 1'b1;
        end else begin
          FREEZE = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign dmem_we    = MemWrite1_PR;
  assign dmem_addr  = {aluResult1_PR[31:2], 2'b00};
  assign dmem_be    = lane_be(mem_size, lane);
  assign dmem_wdata = lane_wdata(mem_size, readDataB1_PR);

  assign Data1_MEM          = aluResult1_PR;
  assign writeRegister1_MEM = writeRegister1_PR;
  assign do_writeback1_MEM  = valid_in & do_writeback1_PR & ~MemRead1_PR;

  // MEM/WB boundary: a frozen, aborted or trapped instruction enters WB as a bubble
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state             <= S_IDLE;
      wait_cnt          <= '0;
      bus_err           <= 1'b0;
      aluResult1_WB     <= '0;
      memData1_WB       <= '0;
      writeRegister1_WB <= '0;
      do_writeback1_WB  <= 1'b0;
      MemtoReg1_WB      <= 1'b0;
    end else begin
      state             <= state_n;
      wait_cnt          <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
      if (abort) bus_err <= 1'b1;
      aluResult1_WB     <= aluResult1_PR;
      memData1_WB       <= load_extend(mem_size, lane, mem_signed, dmem_rdata);
      writeRegister1_WB <= writeRegister1_PR;
      MemtoReg1_WB      <= MemtoReg1_PR;
      do_writeback1_WB  <= valid_in & do_writeback1_PR & ~FREEZE & ~abort & ~misalign;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge CLK) begin
    if (RESET)         misalign_err <= 1'b0;
    else if (misalign) misalign_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, sized stores/loads, multi-cycle ack,
// timeout bus error, reset during WAIT and MEM forwarding.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        valid_in;
  logic [31:0] aluResult1_PR, readDataB1_PR;
  logic [4:0]  writeRegister1_PR;
  logic        do_writeback1_PR, MemRead1_PR, MemWrite1_PR, MemtoReg1_PR;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        FREEZE;
  logic [31:0] Data1_MEM;
  logic [4:0]  writeRegister1_MEM;
  logic        do_writeback1_MEM;
  logic [31:0] aluResult1_WB, memData1_WB;
  logic [4:0]  writeRegister1_WB;
  logic        do_writeback1_WB, MemtoReg1_WB;
  logic        bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int errors = 0;
  int checks = 0;
  int frz_cycles;
  logic req_seen;

  always #5 CLK = ~CLK;

  mem_stage #(.TIMEOUT(64), .CNT_W(7)) dut (
    .CLK(CLK), .RESET(RESET), .valid_in(valid_in),
    .aluResult1_PR(aluResult1_PR), .readDataB1_PR(readDataB1_PR),
    .writeRegister1_PR(writeRegister1_PR), .do_writeback1_PR(do_writeback1_PR),
    .MemRead1_PR(MemRead1_PR), .MemWrite1_PR(MemWrite1_PR), .MemtoReg1_PR(MemtoReg1_PR),
    .mem_size(mem_size), .mem_signed(mem_signed),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .FREEZE(FREEZE), .Data1_MEM(Data1_MEM), .writeRegister1_MEM(writeRegister1_MEM),
    .do_writeback1_MEM(do_writeback1_MEM), .aluResult1_WB(aluResult1_WB),
    .memData1_WB(memData1_WB), .writeRegister1_WB(writeRegister1_WB),
    .do_writeback1_WB(do_writeback1_WB), .MemtoReg1_WB(MemtoReg1_WB),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
`endif
    .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd, input logic wb, input logic rd_en,
                        input logic wr_en, input logic m2r, input logic [1:0] sz,
                        input logic sg);
    valid_in = v; aluResult1_PR = a; readDataB1_PR = d; writeRegister1_PR = rd;
    do_writeback1_PR = wb; MemRead1_PR = rd_en; MemWrite1_PR = wr_en;
    MemtoReg1_PR = m2r; mem_size = sz; mem_signed = sg;
  endtask

  initial begin
    RESET = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    set_op(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    tick(); tick();
    RESET = 1'b0;
    #1;
    check("rst_do_wb_WB", 32'(do_writeback1_WB), 32'd0);
    check("rst_alu_WB", aluResult1_WB, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_freeze", 32'(FREEZE), 32'd0);

    // ALU op: latency 1, no memory request
    tick();
    set_op(1'b1, 32'h0000_1234, '0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    #1;
    check("alu_req", 32'(dmem_req), 32'd0);
    check("alu_fwd_data", Data1_MEM, 32'h0000_1234);
    check("alu_fwd_valid", 32'(do_writeback1_MEM), 32'd1);
    tick();
    set_op(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    check("alu_WB_data", aluResult1_WB, 32'h0000_1234);
    check("alu_WB_rd", 32'(writeRegister1_WB), 32'd5);
    check("alu_WB_valid", 32'(do_writeback1_WB), 32'd1);
    #1;
    check("bubble_req", 32'(dmem_req), 32'd0);
    tick();
    check("bubble_WB_valid", 32'(do_writeback1_WB), 32'd0);

    // Byte store with same-cycle ack
    set_op(1'b1, 32'h0000_0103, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    dmem_ack = 1'b1;
    #1;
    check("sb_req", 32'(dmem_req), 32'd1);
    check("sb_we", 32'(dmem_we), 32'd1);
    check("sb_be", 32'(dmem_be), 32'b1000);
    check("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    check("sb_addr", dmem_addr, 32'h0000_0100);
    check("sb_freeze", 32'(FREEZE), 32'd0);

    // Half store, upper lane
    tick();
    set_op(1'b1, 32'h0000_0102, 32'h1234_CDEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    #1;
    check("sh_be", 32'(dmem_be), 32'b1100);
    check("sh_wdata", dmem_wdata, 32'hCDEF_CDEF);

    // Unsigned byte load lane 1, rd=7: not forwardable from MEM
    tick();
    set_op(1'b1, 32'h0000_0301, '0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    dmem_rdata = 32'h1122_8344;
    #1;
    check("lbu_we", 32'(dmem_we), 32'd0);
    check("lbu_be", 32'(dmem_be), 32'b0010);
    check("ld_fwd_valid", 32'(do_writeback1_MEM), 32'd0);
    check("ld_fwd_rd", 32'(writeRegister1_MEM), 32'd7);
    tick();
    check("lbu_data", memData1_WB, 32'h0000_0083);
    check("lbu_WB_valid", 32'(do_writeback1_WB), 32'd1);
    check("lbu_m2r", 32'(MemtoReg1_WB), 32'd1);

    // Signed byte load, same lane
    mem_signed = 1'b1;
    tick();
    check("lb_data", memData1_WB, 32'hFFFF_FF83);

    // Misaligned word load silently aligned
    set_op(1'b1, 32'h0000_0407, '0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    dmem_rdata = 32'hCAFE_F00D;
    #1;
    check("lw_addr", dmem_addr, 32'h0000_0404);
    check("lw_be", 32'(dmem_be), 32'b1111);
    tick();
    check("lw_data", memData1_WB, 32'hCAFE_F00D);

    // ALU op to rd=7 forwards
    set_op(1'b1, 32'h0000_0777, '0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    dmem_ack = 1'b0;
    #1;
    check("alu7_fwd_valid", 32'(do_writeback1_MEM), 32'd1);
    check("alu7_fwd_data", Data1_MEM, 32'h0000_0777);

    // Signed half load, ack in the fourth request cycle
    tick();
    set_op(1'b1, 32'h0000_0202, '0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1);
    dmem_rdata = 32'h8001_7FFF;
    frz_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      dmem_ack = (k == 3);
      #1;
      if (FREEZE) frz_cycles++;
      check("lh_req_hold", 32'(dmem_req), 32'd1);
      check("lh_addr_hold", dmem_addr, 32'h0000_0200);
      check("lh_be_hold", 32'(dmem_be), 32'b1100);
      if (k == 1) check("lh_frozen_bubble", 32'(do_writeback1_WB), 32'd0);
      tick();
    end
    dmem_ack = 1'b0;
    set_op(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    check("lh_freeze_cycles", 32'(frz_cycles), 32'd3);
    check("lh_data", memData1_WB, 32'hFFFF_8001);
    check("lh_WB_valid", 32'(do_writeback1_WB), 32'd1);
    #1;
    check("lh_done_req", 32'(dmem_req), 32'd0);

    // Word load that never gets an ack
    tick();
    set_op(1'b1, 32'h0000_0400, '0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    frz_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!FREEZE) break;
      frz_cycles++;
      tick();
    end
    check("to_freeze_cycles", 32'(frz_cycles), 32'd64);
    tick();
    set_op(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_WB_valid", 32'(do_writeback1_WB), 32'd0);
    #1;
    check("to_req_idle", 32'(dmem_req), 32'd0);

    // Fill WB with nonzero values, then reset while waiting on a load
    tick();
    set_op(1'b1, 32'hDEAD_0000, '0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    tick();
    check("pre_rst_alu_WB", aluResult1_WB, 32'hDEAD_0000);
    check("sticky_bus_err", 32'(bus_err), 32'd1);
    set_op(1'b1, 32'h0000_0500, '0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    dmem_rdata = 32'h5555_AAAA;
    tick();
    check("wait_freeze", 32'(FREEZE), 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    set_op(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    #1;
    check("rstw_req", 32'(dmem_req), 32'd0);
    check("rstw_freeze", 32'(FREEZE), 32'd0);
    check("rstw_alu_WB", aluResult1_WB, 32'd0);
    check("rstw_mem_WB", memData1_WB, 32'd0);
    check("rstw_rd_WB", 32'(writeRegister1_WB), 32'd0);
    check("rstw_m2r_WB", 32'(MemtoReg1_WB), 32'd0);
    check("rstw_bus_err", 32'(bus_err), 32'd0);
    tick();
    check("rstw_idle_req", 32'(dmem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
